gps_msg_gen: RTL

//  Navigation-data bit source feeding gps_gen_core's message selector. Counts chips (one per ena_in),

---
 rtl/gps_gen_pkg.sv | 13 +
 rtl/msg_bit_fifo.sv | 64 ++++++
 rtl/gps_msg_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/gps_gen_pkg.sv
// Shared GPS signal-generator constants and the navigation-bit source selector.
package gps_gen_pkg;

  localparam int unsigned GPS_CHIPS_PER_CODE = 1023;
  localparam int unsigned GPS_CODES_PER_BIT  = 20;
  localparam logic [7:0]  GPS_PREAMBLE       = 8'h8B;

  typedef enum logic {
    SRC_FIFO   = 1'b0,
    SRC_PRESET = 1'b1
  } msg_src_e;

endpackage

// File: rtl/msg_bit_fifo.sv
// 1-bit synchronous FIFO for user navigation message bits; DEPTH must be a power of 2.
module msg_bit_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];

  // A push is judged against the fullness at the start of the cycle, so a
  // simultaneous pop never frees room for it.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din_i;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gps_msg_gen.sv
// Navigation data-bit source: chip/code counters, epoch and bit-start strobes, preset or FIFO bits.
module gps_msg_gen
  import gps_gen_pkg::*;
#(
  parameter int unsigned            CHIPS_PER_CODE = GPS_CHIPS_PER_CODE,
  parameter int unsigned            CODES_PER_BIT  = GPS_CODES_PER_BIT,
  parameter int unsigned            PRESET_LEN     = 8,
  parameter logic [PRESET_LEN-1:0]  PRESET_WORD    = GPS_PREAMBLE,
  parameter int unsigned            FIFO_DEPTH     = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic ena_in,
  input  logic restart_in,
  input  logic use_msg_preset_in,
  input  logic msg_in,
  input  logic msg_valid_in,
  output logic msg_ready_out,
  output logic data_bit_out,
  output logic epoch_out,
  output logic bit_start_out,
  output logic underrun_out
);

  localparam int unsigned CW = $clog2(CHIPS_PER_CODE);
  localparam int unsigned BW = $clog2(CODES_PER_BIT);
  localparam int unsigned PW = $clog2(PRESET_LEN);

  logic [CW-1:0] chip_cnt_q, chip_cnt_d;
  logic [BW-1:0] code_cnt_q, code_cnt_d;
  logic [PW-1:0] preset_ptr_q, preset_ptr_d;
  logic          data_bit_q, data_bit_d;
  logic          epoch_q, epoch_d;
  logic          bit_start_q, bit_start_d;
  logic          underrun_q, underrun_d;

  logic          chip_zero, code_zero;
  logic          fifo_pop, fifo_head, fifo_full, fifo_empty;
  msg_src_e      src;

  assign chip_zero = (chip_cnt_q == '0);
  assign code_zero = (code_cnt_q == '0);
  assign src       = msg_src_e'(use_msg_preset_in);

  msg_bit_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .push_i (msg_valid_in),
    .din_i  (msg_in),
    .pop_i  (fifo_pop),
    .dout_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    chip_cnt_d   = chip_cnt_q;
    code_cnt_d   = code_cnt_q;
    preset_ptr_d = preset_ptr_q;
    data_bit_d   = data_bit_q;
    underrun_d   = underrun_q;
    epoch_d      = 1'b0;
    bit_start_d  = 1'b0;
    fifo_pop     = 1'b0;

    // restart_in overrides a coincident chip strobe; the current bit is held.
    if (restart_in) begin
      chip_cnt_d   = '0;
      code_cnt_d   = '0;
      preset_ptr_d = '0;
      underrun_d   = 1'b0;
    end else if (ena_in) begin
      epoch_d     = chip_zero;
      bit_start_d = chip_zero & code_zero;

      if (chip_cnt_q == CW'(CHIPS_PER_CODE - 1)) begin
        chip_cnt_d = '0;
        code_cnt_d = (code_cnt_q == BW'(CODES_PER_BIT - 1)) ? '0 : code_cnt_q + BW'(1);
      end else begin
        chip_cnt_d = chip_cnt_q + CW'(1);
      end

      if (chip_zero & code_zero) begin
        if (src == SRC_PRESET) begin
          data_bit_d   = PRESET_WORD[PW'(PRESET_LEN - 1) - preset_ptr_q];
          preset_ptr_d = (preset_ptr_q == PW'(PRESET_LEN - 1)) ? '0 : preset_ptr_q + PW'(1);
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          data_bit_d = fifo_head;
        end else begin
          data_bit_d = 1'b0;
          underrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      chip_cnt_q   <= '0;
      code_cnt_q   <= '0;
      preset_ptr_q <= '0;
      data_bit_q   <= 1'b0;
      epoch_q      <= 1'b0;
      bit_start_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      chip_cnt_q   <= chip_cnt_d;
      code_cnt_q   <= code_cnt_d;
      preset_ptr_q <= preset_ptr_d;
      data_bit_q   <= data_bit_d;
      epoch_q      <= epoch_d;
      bit_start_q  <= bit_start_d;
      underrun_q   <= underrun_d;
    end
  end

  assign msg_ready_out = ~fifo_full;
  assign data_bit_out  = data_bit_q;
  assign epoch_out     = epoch_q;
  assign bit_start_out = bit_start_q;
  assign underrun_out  = underrun_q;

endmodule
